// File: rtl/clk_meter_pkg.sv
// Shared constants for the clock period meter: FSM state encodings,
// system clock frequency and the default counter width / timeout.
package clk_meter_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_EDGE = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;

  localparam int CLK_HZ      = 48_000_000;
  localparam int DEF_CNT_W   = 20;
  // 20 ms at 48 MHz, roughly a 50 Hz floor on the measurable input.
  localparam int DEF_TIMEOUT = 960_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered edge detector.
// rise/fall are one-cycle pulses appearing 3 clk cycles after the input
// transition; level is the synchronized input. Also usable for buttons.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

  // Synchronize the input and register edge pulses against the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign level = sync2_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rising-to-rising period and rising-to-falling high time of a
// slow asynchronous input, in clk cycles. A sticky timeout flags a stuck
// input. Optional macro CLK_PERIOD_METER_CONTINUOUS_EN keeps measuring
// back-to-back periods after each result, and lets start abort a run.
//
// state     | meaning
// IDLE      | waiting for a start request
// WAIT_EDGE | armed, waiting for the opening rising edge
// MEASURE   | counting from the opening rise to the closing rise
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(DEF_TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  logic             rise, fall;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             count_hit;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .rise     (rise),
    .fall     (fall),
    .level    ()
  );

  assign count_hit = (count_q == TIMEOUT);

  // Next-state logic: a closing edge always beats a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_cap_d    = hi_cap_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        // A rise coinciding with start is deliberately not an opening edge.
        if (start) begin
          state_d   = WAIT_EDGE;
          count_d   = CNT_W'(1);
          timeout_d = 1'b0;
        end
      end
      WAIT_EDGE: begin
        count_d = count_q + CNT_W'(1);
        if (rise) begin
          state_d = MEASURE;
          count_d = CNT_W'(1);
        end else if (count_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      MEASURE: begin
        count_d = count_q + CNT_W'(1);
        if (fall) begin
          hi_cap_d = count_q;
        end
        if (rise) begin
          period_d    = count_q;
          high_time_d = hi_cap_q;
          valid_d     = 1'b1;
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
          // Closing rise doubles as the opening edge of the next period.
          count_d = CNT_W'(1);
`else
          state_d = IDLE;
`endif
        end else if (count_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
    // In continuous mode start while busy stops measuring without a result.
    if (start && (state_q != IDLE)) begin
      state_d     = IDLE;
      valid_d     = 1'b0;
      period_d    = period_q;
      high_time_d = high_time_q;
      timeout_d   = timeout_q;
    end
`endif
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      hi_cap_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;

endmodule
